direction_queue: RTL and testbench

Multi-player, buffered turn controller for the snake game. It sits between the debounced button inputs and the game-tick movement logic. Per player, it edge-detects button presses and rejects reversals and redundant turns. Accepted turns go into a small FIFO, and one queued turn is committed per game step, so quick turn sequences such as right→up→left made between two steps are not lost.

---
 rtl/direction_queue.sv | 157 +++++++++++++++
 tb/tb_direction_queue.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/direction_queue.sv
// direction_queue: buffered per-player turn controller for the snake game.
// Each player channel edge-detects its four direction buttons. It rejects
// reversals and redundant turns, queues accepted turns in a small circular
// FIFO, and commits one queued turn per game step. Channels share only
// clk, rst and step. All outputs come straight from flops.
module direction_queue #(
  parameter int         PLAYERS  = 2,
  parameter int         DEPTH    = 2,
  parameter logic [1:0] INIT_DIR = 2'b10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*PLAYERS-1:0]   btn,
  input  logic                   step,
  output logic [2*PLAYERS-1:0]   direction,
  output logic [PLAYERS-1:0]     turned,
  output logic [PLAYERS-1:0]     dropped,
  output logic [PLAYERS-1:0]     full
);

  // Direction encodings; bit0 distinguishes the two members of an axis,
  // so the opposite of d is d ^ 2'b01.
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  // Pointer width is kept at least 1 so DEPTH=1 still has a legal vector.
  // The count must hold 0..DEPTH inclusive.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_player

    // Channel state
    logic [3:0]    btn_q_reg;
    logic [1:0]    mem_reg [DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [1:0]    dir_reg;
    logic          turned_reg;
    logic          dropped_reg;
    logic          full_reg;

    // Combinational next-state terms
    logic [3:0]    btn_now;
    logic [3:0]    press;
    logic          req_valid;
    logic [1:0]    req;
    logic [PW-1:0] tail_ptr;
    logic [1:0]    ref_dir;
    logic          queue_full;
    logic          pop;
    logic          reject;
    logic          push;
    logic [PW-1:0] rd_ptr_next;
    logic [PW-1:0] wr_ptr_next;
    logic [CW-1:0] count_next;

    assign btn_now = btn[4*gi +: 4];

    // Rising-edge detect and fixed-priority request select (up > down > right > left).
    // Extra simultaneous presses are discarded without a dropped pulse.
    always_comb begin
      press     = btn_now & ~btn_q_reg;
      req_valid = 1'b0;
      req       = DIR_UP;
      if (press[0]) begin
        req_valid = 1'b1;
        req       = DIR_UP;
      end else if (press[1]) begin
        req_valid = 1'b1;
        req       = DIR_DOWN;
      end else if (press[2]) begin
        req_valid = 1'b1;
        req       = DIR_RIGHT;
      end else if (press[3]) begin
        req_valid = 1'b1;
        req       = DIR_LEFT;
      end
    end

    // Validate the request against the last direction the snake will have
    // taken: the newest queued turn, or the committed direction if the queue is empty.
    always_comb begin
      tail_ptr   = (wr_ptr_reg == '0) ? PTR_LAST : wr_ptr_reg - 1'b1;
      ref_dir    = (count_reg != '0) ? mem_reg[tail_ptr] : dir_reg;
      queue_full = (count_reg == COUNT_MAX);
      pop        = step && (count_reg != '0);
      reject     = req_valid &&
                   ((req == ref_dir) ||
                    (req == (ref_dir ^ 2'b01)) ||
                    (queue_full && !pop));
      push       = req_valid && !reject;
    end

    // Circular pointer and occupancy update; wraps at DEPTH, not at a power of two.
    always_comb begin
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      count_next  = count_reg;
      if (pop) begin
        rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
      end
      if (push) begin
        wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_next = count_reg + 1'b1;
      end else if (pop && !push) begin
        count_next = count_reg - 1'b1;
      end
    end

    // Control state and registered outputs; reset wins over btn and step.
    always_ff @(posedge clk) begin
      if (rst) begin
        btn_q_reg   <= '0;
        rd_ptr_reg  <= '0;
        wr_ptr_reg  <= '0;
        count_reg   <= '0;
        dir_reg     <= INIT_DIR;
        turned_reg  <= 1'b0;
        dropped_reg <= 1'b0;
        full_reg    <= 1'b0;
      end else begin
        btn_q_reg   <= btn_now;
        rd_ptr_reg  <= rd_ptr_next;
        wr_ptr_reg  <= wr_ptr_next;
        count_reg   <= count_next;
        if (pop) begin
          dir_reg <= mem_reg[rd_ptr_reg];
        end
        turned_reg  <= pop;
        dropped_reg <= reject;
        full_reg    <= (count_next == COUNT_MAX);
      end
    end

    // Queue storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
      if (!rst && push) begin
        mem_reg[wr_ptr_reg] <= req;
      end
    end

    assign direction[2*gi +: 2] = dir_reg;
    assign turned[gi]           = turned_reg;
    assign dropped[gi]          = dropped_reg;
    assign full[gi]             = full_reg;
  end

endmodule

// File: tb/tb_direction_queue.sv
// Testbench for direction_queue with PLAYERS=2, DEPTH=2, INIT_DIR=RIGHT.
// A per-cycle vector table drives rst/btn/step and states the expected
// registered outputs after each edge. Hand-written sequences cover a held
// button and a reset in the middle of a run.
module tb_direction_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] btn = 8'h00;
  logic       step = 1'b0;
  logic [3:0] direction;
  logic [1:0] turned;
  logic [1:0] dropped;
  logic [1:0] full;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [7:0] btn;
    logic       step;
    logic [3:0] dir;
    logic [1:0] turned;
    logic [1:0] dropped;
    logic [1:0] full;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  direction_queue #(
    .PLAYERS (2),
    .DEPTH   (2),
    .INIT_DIR(2'b10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .step     (step),
    .direction(direction),
    .turned   (turned),
    .dropped  (dropped),
    .full     (full)
  );

  function automatic vec_t mk(logic r, logic [7:0] b, logic s, logic [3:0] d,
                              logic [1:0] t, logic [1:0] dr, logic [1:0] f);
    vec_t v;
    v.rst = r; v.btn = b; v.step = s; v.dir = d;
    v.turned = t; v.dropped = dr; v.full = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cycle(input logic r, input logic [7:0] b, input logic s);
    rst = r; btn = b; step = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // dir column is {p1, p0}: 10=RIGHT 00=UP 01=DOWN 11=LEFT
    // Reset with all buttons held, then up wins on release
    vecs.push_back(mk(1, 8'hFF, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 8'hFF, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'hFF, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'hFF, 1, 4'b0000, 2'b11, 2'b00, 2'b00));
    // Single turn on P0, P1 untouched
    vecs.push_back(mk(1, 8'h00, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h01, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h01, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h00, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h00, 1, 4'b1000, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h00, 0, 4'b1000, 2'b00, 2'b00, 2'b00));
    // Quick sequence up, left, then three steps
    vecs.push_back(mk(1, 8'h00, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h01, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h08, 0, 4'b1010, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk(0, 8'h00, 1, 4'b1000, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h00, 1, 4'b1011, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h00, 1, 4'b1011, 2'b00, 2'b00, 2'b00));
    // Rejections from RIGHT with empty queue
    vecs.push_back(mk(1, 8'h00, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h08, 0, 4'b1010, 2'b00, 2'b01, 2'b00));
    vecs.push_back(mk(0, 8'h00, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h04, 0, 4'b1010, 2'b00, 2'b01, 2'b00));
    vecs.push_back(mk(0, 8'h00, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h05, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h00, 1, 4'b1000, 2'b01, 2'b00, 2'b00));
    // Overflow without a step: down dropped, queue intact
    vecs.push_back(mk(1, 8'h00, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h01, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h08, 0, 4'b1010, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk(0, 8'h02, 0, 4'b1010, 2'b00, 2'b01, 2'b01));
    vecs.push_back(mk(0, 8'h00, 1, 4'b1000, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h00, 1, 4'b1011, 2'b01, 2'b00, 2'b00));
    // Overflow with a coinciding step: down accepted, full stays
    vecs.push_back(mk(1, 8'h00, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h01, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h08, 0, 4'b1010, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk(0, 8'h02, 1, 4'b1000, 2'b01, 2'b00, 2'b01));
    vecs.push_back(mk(0, 8'h00, 1, 4'b1011, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h00, 1, 4'b1001, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h00, 1, 4'b1001, 2'b00, 2'b00, 2'b00));
    // Player 1 independence: reversal dropped, then up committed
    vecs.push_back(mk(1, 8'h00, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h80, 0, 4'b1010, 2'b00, 2'b10, 2'b00));
    vecs.push_back(mk(0, 8'h10, 0, 4'b1010, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 8'h00, 1, 4'b0010, 2'b10, 2'b00, 2'b00));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].btn, vecs[i].step);
      $display("vec %0d rst=%b btn=%h step=%b dir=%b turned=%b dropped=%b full=%b",
               i, vecs[i].rst, vecs[i].btn, vecs[i].step, direction, turned, dropped, full);
      check($sformatf("vec%0d_dir", i),     direction,        vecs[i].dir);
      check($sformatf("vec%0d_turned", i),  {2'b00, turned},  {2'b00, vecs[i].turned});
      check($sformatf("vec%0d_dropped", i), {2'b00, dropped}, {2'b00, vecs[i].dropped});
      check($sformatf("vec%0d_full", i),    {2'b00, full},    {2'b00, vecs[i].full});
    end

    // Held button: ten cycles of up must yield exactly one queued entry
    cycle(1, 8'h00, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 8'h01, 0);
      $display("held %0d dir=%b dropped=%b full=%b", i, direction, dropped, full);
      check($sformatf("held%0d_full", i),    {2'b00, full},    4'b0000);
      check($sformatf("held%0d_dropped", i), {2'b00, dropped}, 4'b0000);
    end
    cycle(0, 8'h00, 1);
    $display("held step1 dir=%b turned=%b", direction, turned);
    check("held_step1_dir",    direction,        4'b1000);
    check("held_step1_turned", {2'b00, turned},  4'b0001);
    cycle(0, 8'h00, 1);
    $display("held step2 dir=%b turned=%b", direction, turned);
    check("held_step2_dir",    direction,        4'b1000);
    check("held_step2_turned", {2'b00, turned},  4'b0000);

    // Mid-run reset with two entries queued; reset also overrides step
    cycle(1, 8'h00, 0);
    cycle(0, 8'h01, 0);
    cycle(0, 8'h08, 0);
    $display("midrst queued dir=%b full=%b", direction, full);
    check("midrst_full_before", {2'b00, full}, 4'b0001);
    cycle(1, 8'h00, 1);
    $display("midrst reset dir=%b turned=%b full=%b", direction, turned, full);
    check("midrst_dir",    direction,       4'b1010);
    check("midrst_turned", {2'b00, turned}, 4'b0000);
    check("midrst_full",   {2'b00, full},   4'b0000);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 8'h00, 1);
      $display("midrst step %0d dir=%b turned=%b", i, direction, turned);
      check($sformatf("midrst_step%0d_dir", i),    direction,       4'b1010);
      check($sformatf("midrst_step%0d_turned", i), {2'b00, turned}, 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
